video_timing_generator: RTL

Parametrised raster timing generator for the FPGA display path. It divides the system clock into a pixel strobe and produces hsync and vsync with configurable polarity. It also outputs visible-region flags, pixel coordinates, and line/frame start pulses for the frame-buffer fetch logic. An `enable` input starts the raster, and a stop request takes effect only at a frame boundary, so the monitor never sees a truncated frame.

---
 rtl/video_timing_generator.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/video_timing_generator.sv
`default_nettype none
// ============================================================================
// Module  : video_timing_generator
// Brief   : Divided pixel strobe, sync/visible/coordinate decode, frame-boundary stop.
// Revision: 1.0
// ============================================================================
module video_timing_generator #(
  parameter int H_VISIBLE         = 640,
  parameter int H_FRONT_PORCH     = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BACK_PORCH      = 48,
  parameter int V_VISIBLE         = 480,
  parameter int V_FRONT_PORCH     = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BACK_PORCH      = 33,
  parameter int CLOCK_DIVIDE      = 2,
  parameter int HSYNC_ACTIVE_HIGH = 0,
  parameter int VSYNC_ACTIVE_HIGH = 0,
  parameter int COORD_WIDTH       = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   pixel_enable,
  output logic                   in_visible_region,
  output logic [COORD_WIDTH-1:0] pixel_x,
  output logic [COORD_WIDTH-1:0] pixel_y,
  output logic                   new_line,
  output logic                   new_frame,
  output logic                   idle
);

  localparam int H_TOTAL = H_FRONT_PORCH + H_SYNC + H_BACK_PORCH + H_VISIBLE;
  localparam int V_TOTAL = V_FRONT_PORCH + V_SYNC + V_BACK_PORCH + V_VISIBLE;
  localparam int H_BLANK = H_TOTAL - H_VISIBLE;
  localparam int V_BLANK = V_TOTAL - V_VISIBLE;
  localparam int DIV_W   = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;

  localparam logic [DIV_W-1:0]       C_DIV_LAST  = DIV_W'(CLOCK_DIVIDE - 1);
  localparam logic [COORD_WIDTH-1:0] C_H_LAST    = COORD_WIDTH'(H_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] C_V_LAST    = COORD_WIDTH'(V_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] C_HS_START  = COORD_WIDTH'(H_FRONT_PORCH);
  localparam logic [COORD_WIDTH-1:0] C_HS_END    = COORD_WIDTH'(H_FRONT_PORCH + H_SYNC);
  localparam logic [COORD_WIDTH-1:0] C_VS_START  = COORD_WIDTH'(V_FRONT_PORCH);
  localparam logic [COORD_WIDTH-1:0] C_VS_END    = COORD_WIDTH'(V_FRONT_PORCH + V_SYNC);
  localparam logic [COORD_WIDTH-1:0] C_H_BLANK   = COORD_WIDTH'(H_BLANK);
  localparam logic [COORD_WIDTH-1:0] C_V_BLANK   = COORD_WIDTH'(V_BLANK);
  localparam logic                   C_HS_ON     = (HSYNC_ACTIVE_HIGH != 0);
  localparam logic                   C_VS_ON     = (VSYNC_ACTIVE_HIGH != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_enable;
  logic [DIV_W-1:0]       r_div;
  logic [COORD_WIDTH-1:0] r_h;
  logic [COORD_WIDTH-1:0] r_v;
  logic                   r_hs;
  logic                   r_vs;
  logic                   r_vis;
  logic [COORD_WIDTH-1:0] r_px;
  logic [COORD_WIDTH-1:0] r_py;

  logic                   w_running;
  logic                   w_pix_en;
  logic                   w_h_last;
  logic                   w_v_last;
  logic                   w_frame_end;
  logic [DIV_W-1:0]       w_div_nxt;
  logic [COORD_WIDTH-1:0] w_h_nxt;
  logic [COORD_WIDTH-1:0] w_v_nxt;
  logic                   w_hs_nxt;
  logic                   w_vs_nxt;
  logic                   w_h_vis_nxt;
  logic                   w_v_vis_nxt;
  logic [COORD_WIDTH-1:0] w_px_nxt;
  logic [COORD_WIDTH-1:0] w_py_nxt;

  assign w_running   = (r_state != IDLE);
  assign w_pix_en    = w_running && (r_div == C_DIV_LAST);
  assign w_h_last    = (r_h == C_H_LAST);
  assign w_v_last    = (r_v == C_V_LAST);
  assign w_frame_end = w_pix_en && w_h_last && w_v_last;

  assign w_div_nxt = (r_div == C_DIV_LAST) ? '0 : r_div + DIV_W'(1);
  assign w_h_nxt   = !w_pix_en ? r_h : (w_h_last ? '0 : r_h + COORD_WIDTH'(1));
  assign w_v_nxt   = !(w_pix_en && w_h_last) ? r_v : (w_v_last ? '0 : r_v + COORD_WIDTH'(1));

  // Outputs are decoded from the position the counters are about to hold, then registered.
  assign w_hs_nxt    = (w_h_nxt >= C_HS_START && w_h_nxt < C_HS_END) ? C_HS_ON : ~C_HS_ON;
  assign w_vs_nxt    = (w_v_nxt >= C_VS_START && w_v_nxt < C_VS_END) ? C_VS_ON : ~C_VS_ON;
  assign w_h_vis_nxt = (w_h_nxt >= C_H_BLANK);
  assign w_v_vis_nxt = (w_v_nxt >= C_V_BLANK);
  assign w_px_nxt    = w_h_vis_nxt ? (w_h_nxt - C_H_BLANK) : '0;
  assign w_py_nxt    = w_v_vis_nxt ? (w_v_nxt - C_V_BLANK) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_enable <= 1'b0;
      r_div    <= '0;
      r_h      <= '0;
      r_v      <= '0;
      r_hs     <= ~C_HS_ON;
      r_vs     <= ~C_VS_ON;
      r_vis    <= 1'b0;
      r_px     <= '0;
      r_py     <= '0;
    end else begin
      r_enable <= enable;
      case (r_state)
        IDLE: begin
          if (r_enable) begin
            r_state <= RUN;
            r_div   <= '0;
            r_h     <= '0;
            r_v     <= '0;
            r_hs    <= w_hs_nxt;
            r_vs    <= w_vs_nxt;
            r_vis   <= w_h_vis_nxt && w_v_vis_nxt;
            r_px    <= w_px_nxt;
            r_py    <= w_py_nxt;
          end
        end
        RUN, STOPPING: begin
          if (r_state == STOPPING && !r_enable && w_frame_end) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_h     <= '0;
            r_v     <= '0;
            r_hs    <= ~C_HS_ON;
            r_vs    <= ~C_VS_ON;
            r_vis   <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
          end else begin
            r_div <= w_div_nxt;
            r_h   <= w_h_nxt;
            r_v   <= w_v_nxt;
            r_hs  <= w_hs_nxt;
            r_vs  <= w_vs_nxt;
            r_vis <= w_h_vis_nxt && w_v_vis_nxt;
            r_px  <= w_px_nxt;
            r_py  <= w_py_nxt;
            if (r_state == RUN && !r_enable) begin
              r_state <= STOPPING;
            end else if (r_state == STOPPING && r_enable) begin
              r_state <= RUN;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign vga_hs            = r_hs;
  assign vga_vs            = r_vs;
  assign in_visible_region = r_vis;
  assign pixel_x           = r_px;
  assign pixel_y           = r_py;
  assign pixel_enable      = w_pix_en;
  assign new_line          = w_pix_en && (r_h == '0);
  assign new_frame         = w_pix_en && (r_h == '0) && (r_v == '0);
  assign idle              = (r_state == IDLE);

endmodule
`default_nettype wire
